stall_ctrl: RTL and testbench

Pipeline stall controller for the 5-stage MIPS core. It generates the enables for the PC register and the F/D pipeline register, and the bubble-insert clear for the D/E register. Stall sources are load-use and other data hazards reported by the D-stage hazard decoder, and the multi-cycle multiply/divide unit, whose busy interval is timed here. It sits beside the hazard decoder and drives `EN` of the F/D register directly.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/stall_ctrl_if.sv | 25 ++
 rtl/md_busy_timer.sv | 71 +++++++
 rtl/stall_ctrl.sv | 43 ++++
 tb/tb_stall_ctrl.sv | 129 ++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: mult/div timer state and the latency
// constants that the mult/div datapath must agree with.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stall_ctrl_if.sv
// Hazard/stall bundle between the D-stage hazard decoder and the stall controller.
interface stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             data_hazD;
    logic             md_useD;
    logic             md_startE;
    logic             md_divE;
    logic             en_pc;
    logic             en_fd;
    logic             clr_de;
    logic             md_busy;
    logic             md_err;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output data_hazD, md_useD, md_startE, md_divE,
        input  en_pc, en_fd, clr_de, md_busy, md_err, stall_cnt
    );

    modport slave (
        input  data_hazD, md_useD, md_startE, md_divE,
        output en_pc, en_fd, clr_de, md_busy, md_err, stall_cnt
    );
endinterface

// File: rtl/md_busy_timer.sv
// Times the mult/div busy interval: a start loads the cycle count, BUSY lasts
// exactly that many cycles; a start while busy is dropped and flagged sticky.
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic md_startE,
    input  logic md_divE,
    output logic md_busy,
    output logic md_err
);
    localparam int MD_CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

    generate
        if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_param
            $error("md_busy_timer: MULT_CYCLES and DIV_CYCLES must be >= 1");
        end
    endgenerate

    md_state_e        state, state_n;
    logic [MD_CW-1:0] cnt, cnt_n;
    logic             err, err_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        err_n   = err;
        case (state)
            IDLE: begin
                if (md_startE) begin
                    state_n = BUSY;
                    cnt_n   = md_divE ? MD_CW'(DIV_CYCLES) : MD_CW'(MULT_CYCLES);
                end
            end
            BUSY: begin
                // The unit cannot accept a new op mid-flight; keep timing the current one.
                if (md_startE) err_n = 1'b1;
                if (cnt == MD_CW'(1)) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - MD_CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign md_busy = (state == BUSY);
    assign md_err  = err;

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall controller: freezes PC and F/D, bubbles D/E on data hazards or
// mult/div-busy conflicts, and keeps a saturating count of stalled cycles.
module stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int CNT_W       = 16
) (
    input logic         clk,
    input logic         reset,
    stall_ctrl_if.slave bus
);
    logic             stall;
    logic [CNT_W-1:0] stall_cnt;

    md_busy_timer #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_timer (
        .clk      (clk),
        .reset    (reset),
        .md_startE(bus.md_startE),
        .md_divE  (bus.md_divE),
        .md_busy  (bus.md_busy),
        .md_err   (bus.md_err)
    );

    // The start cycle must already hold an md user, since busy only rises at the edge.
    assign stall = bus.data_hazD | (bus.md_useD & (bus.md_busy | bus.md_startE));

    assign bus.en_pc  = ~stall;
    assign bus.en_fd  = ~stall;
    assign bus.clr_de = stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                          stall_cnt <= '0;
        else if (stall && stall_cnt != '1)   stall_cnt <= stall_cnt + CNT_W'(1);
    end

    assign bus.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_stall_ctrl.sv
// Directed-vector bench for stall_ctrl; a CNT_W=4 copy runs on the same inputs
// to exercise counter saturation.
module tb_stall_ctrl;
    import pipe_ctrl_pkg::*;

    typedef struct {
        int   id;
        logic en;
        logic busy;
        logic err;
        int   cnt;
        int   cnt4;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic hz = 1'b0, use_d = 1'b0, st = 1'b0, dv = 1'b0;

    exp_t q[$];
    int   nvec  = 0;
    int   nfail = 0;
    int   vid   = 0;

    stall_ctrl_if #(.CNT_W(16)) b16 ();
    stall_ctrl_if #(.CNT_W(4))  b4  ();

    assign b16.data_hazD = hz;
    assign b16.md_useD   = use_d;
    assign b16.md_startE = st;
    assign b16.md_divE   = dv;
    assign b4.data_hazD  = hz;
    assign b4.md_useD    = use_d;
    assign b4.md_startE  = st;
    assign b4.md_divE    = dv;

    stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(16)) dut16 (
        .clk(clk), .reset(rst_n), .bus(b16.slave));
    stall_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut4 (
        .clk(clk), .reset(rst_n), .bus(b4.slave));

    always #5 clk = ~clk;

    // Monitor: compare the current cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nvec++;
            if (b16.en_pc !== e.en || b16.en_fd !== e.en || b16.clr_de !== ~e.en ||
                b16.md_busy !== e.busy || b16.md_err !== e.err ||
                b16.stall_cnt !== 16'(e.cnt) || b4.stall_cnt !== 4'(e.cnt4) ||
                b4.md_busy !== e.busy) begin
                nfail++;
                $display("FAIL vec%0d: got en_pc=%b en_fd=%b clr_de=%b busy=%b err=%b cnt=%0d cnt4=%0d, want en=%b clr=%b busy=%b err=%b cnt=%0d cnt4=%0d",
                         e.id, b16.en_pc, b16.en_fd, b16.clr_de, b16.md_busy, b16.md_err,
                         b16.stall_cnt, b4.stall_cnt, e.en, ~e.en, e.busy, e.err, e.cnt, e.cnt4);
            end
        end
    end

    task automatic vec(input logic r, input logic hz_i, input logic use_i, input logic st_i,
                       input logic dv_i, input logic en_e, input logic busy_e,
                       input logic err_e, input int cnt_e);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r; hz = hz_i; use_d = use_i; st = st_i; dv = dv_i;
        e.id   = vid++;
        e.en   = en_e;
        e.busy = busy_e;
        e.err  = err_e;
        e.cnt  = cnt_e;
        e.cnt4 = (cnt_e > 15) ? 15 : cnt_e;
        q.push_back(e);
    endtask

    initial begin
        // reset, then idle
        repeat (2)  vec(0, 0,0,0,0, 1,0,0, 0);
        repeat (10) vec(1, 0,0,0,0, 1,0,0, 0);

        // single-cycle data hazard
        vec(1, 1,0,0,0, 0,0,0, 0);
        repeat (2) vec(1, 0,0,0,0, 1,0,0, 1);

        // mult start with md user held; hazard overlaps busy cycle 2 (single count)
        vec(1, 0,1,1,0, 0,0,0, 1);
        vec(1, 0,1,0,0, 0,1,0, 2);
        vec(1, 1,1,0,0, 0,1,0, 3);
        vec(1, 0,1,0,0, 0,1,0, 4);
        vec(1, 0,1,0,0, 0,1,0, 5);
        vec(1, 0,1,0,0, 0,1,0, 6);
        repeat (2) vec(1, 0,1,0,0, 1,0,0, 7);

        // div start, second start in busy cycle 3 is ignored and flagged
        vec(1, 0,0,1,1, 1,0,0, 7);
        for (int i = 1; i <= 10; i++)
            vec(1, 0,0,(i == 3),0, 1,1,(i > 3), 7);
        repeat (2) vec(1, 0,0,0,0, 1,0,1, 7);

        // div start, async reset in busy cycle 4
        vec(1, 0,0,1,1, 1,0,1, 7);
        repeat (3) vec(1, 0,0,0,0, 1,1,1, 7);
        vec(0, 0,0,0,0, 1,0,0, 0);
        vec(0, 0,0,0,0, 1,0,0, 0);
        repeat (3) vec(1, 0,1,0,0, 1,0,0, 0);

        // held hazard: 4-bit counter saturates at 15
        for (int i = 0; i < 20; i++)
            vec(1, 1,0,0,0, 0,0,0, i);
        repeat (2) vec(1, 0,0,0,0, 1,0,0, 20);

        begin
            int guard = 0;
            while (q.size() > 0 && guard < 20) begin
                @(posedge clk);
                guard++;
            end
            if (q.size() > 0) begin
                nvec++;
                nfail++;
                $display("FAIL drain: %0d expectations left, want 0", q.size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
